pref_issue_queue: RTL and testbench
===================================

Name: pref_issue_queue

Overview:
- Sits between the IP-stride prefetcher (up to 3 candidate prefetch addresses per cycle) and the L2 prefetch request port (one request per cycle, valid/ready).
- Buffers candidates in a circular FIFO, removes duplicate block addresses, drops candidates on overflow and counts the drops.
- Issues the head entry to the cache with a registered valid/ready handshake.
- Supports a flush, e.g. on context switch or mispredict recovery.

Parameters:
- QUEUE_DEPTH, 16, number of FIFO entries; power of two, minimum 4.
- ADDR_SIZE, 64, address width in bits.
- LOG2_BLOCK_SIZE, 6, cache block offset bits.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pref_addr1_i  in  64  candidate 1 address (lowest stride multiple).
- pref_valid1_i  in  1  candidate 1 valid.
- pref_addr2_i  in  64  candidate 2 address.
- pref_valid2_i  in  1  candidate 2 valid.
- pref_addr3_i  in  64  candidate 3 address.
- pref_valid3_i  in  1  candidate 3 valid.
- flush_i  in  1  discard all queued entries.
- issue_addr_o  out  64  head block address; low LOG2_BLOCK_SIZE bits are zero.
- issue_valid_o  out  1  head entry valid.
- issue_ready_i  in  1  cache accepts the request.
- occupancy_o  out  $clog2(QUEUE_DEPTH)+1  current entry count.
- drop_count_o  out  CNT_W  saturating count of candidates dropped on overflow.

Behaviour:
- Reset (rst=1 at the edge): head, tail and count go to 0, and all entry valid bits clear. issue_valid_o=0, issue_addr_o=0, occupancy_o=0, drop_count_o=0. rst overrides flush_i and all inputs, including mid-operation.
- Entries store the block address only: addr >> LOG2_BLOCK_SIZE. On output the address is left-shifted back, so offset bits are zero.
- Pop: issue_valid_o & issue_ready_i at edge N removes the head; head increments modulo QUEUE_DEPTH.
- issue_valid_o and issue_addr_o reflect queue state after edge N.
- issue_addr_o must not change while issue_valid_o=1 and issue_ready_i=0.
- Enqueue order each cycle: candidate 1, then 2, then 3. Only valid candidates are considered.
- A candidate is a duplicate when its block address matches either of:
  - any valid queue entry, including the head being popped this cycle;
  - an earlier candidate in the same cycle.
- Duplicates are silently discarded and are not counted as drops.
- Free slots this cycle = QUEUE_DEPTH - count + (pop ? 1 : 0). This allows simultaneous enqueue and dequeue at full occupancy.
- Non-duplicate candidates fill free slots in order. Any that do not fit are dropped. drop_count_o adds the number dropped and saturates at 2^CNT_W-1, never wrapping.
- Tail advances by the number enqueued (0..3) modulo QUEUE_DEPTH. count_next = count + enq - pop.
- Latency: a candidate presented with the queue empty before edge N is visible as issue_valid_o=1 immediately after edge N (one cycle).
- No bypass from candidate input to output.
- flush_i=1 at an edge: count, head and tail go to 0 and all valid bits clear. Same-cycle candidates are discarded. A same-cycle pop is considered not to have occurred. drop_count_o holds its value.
- Empty queue: issue_valid_o=0; issue_ready_i is ignored.
- Full queue with no pop: all non-duplicate candidates are dropped.
- Pointer wrap: no special case beyond modulo arithmetic. Count, not the pointers, distinguishes full from empty.

Optional Feature:
- Macro: PREF_DEDUP_EN.
- Defined: duplicate filtering as above. A compare block checks 3 candidates against QUEUE_DEPTH entries plus each other.
- Undefined: no comparison logic. Every valid candidate is enqueued in order, subject only to space. Identical addresses may occupy several entries.

Decomposition:
- Package pref_pkg holds:
  - ADDR_SIZE, LOG2_BLOCK_SIZE, LOG2_PAGE_SIZE;
  - addr_t, and cla_t (block address, ADDR_SIZE-LOG2_BLOCK_SIZE bits);
  - struct pref_cand_t {cla_t cla; logic valid;}.
- pref_pkg is also imported by the stride prefetcher.
- One sub-module, pref_dedup_cam: combinational match of 3 candidates against the entry array and valid bits. It outputs a 3-bit keep mask. It is only instantiated under PREF_DEDUP_EN.
- The top level contains the FIFO storage, pointers, counter and handshake.

Test Plan:
- Reset then single candidate: rst 2 cycles; valid1 with addr1=0x1000_0047, ready=1 → next cycle issue_valid_o=1, issue_addr_o=0x1000_0040; following cycle issue_valid_o=0, occupancy 0.
- Triple candidate, stalled cache: addrs 0x2000, 0x2040, 0x2080 all valid, ready=0 for 5 cycles → occupancy 3, issue_addr_o held at 0x2000. Release ready → issued 0x2000, 0x2040, 0x2080 on consecutive cycles.
- Overflow: ready=0, present 3 distinct new blocks every cycle for 6 cycles with DEPTH=16 → occupancy 16, drop_count_o=2. Then ready=1 with 3 new candidates → 1 accepted, drop_count_o=4.
- Dedup (PREF_DEDUP_EN): queue holds 0x3000; present 0x3010, 0x3040, 0x3040 → only one 0x3040 enqueued, occupancy 2, drop_count_o unchanged. Without the macro: occupancy 4.
- Flush vs pop: queue holds 5 entries, ready=1, flush_i=1 with 2 valid candidates → next cycle occupancy 0, issue_valid_o=0, drop_count_o unchanged.
- Wrap and saturation: CNT_W=4, run 40 cycles alternating fill and drain so pointers wrap twice → FIFO order preserved. Force 20 drops → drop_count_o stays at 15.

Source files
------------

// File: rtl/pref_pkg.sv
// Shared prefetch types: address / cache-line-address widths and the candidate bundle.
// Imported by the prefetch issue queue, its dedup CAM and the stride prefetcher.
package pref_pkg;

  localparam int ADDR_SIZE       = 64;
  localparam int LOG2_BLOCK_SIZE = 6;
  localparam int LOG2_PAGE_SIZE  = 12;
  localparam int CLA_SIZE        = ADDR_SIZE - LOG2_BLOCK_SIZE;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [CLA_SIZE-1:0]  cla_t;

  typedef struct packed {
    cla_t cla;
    logic valid;
  } pref_cand_t;

  function automatic cla_t addr_to_cla(input addr_t addr);
    return addr[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  endfunction

endpackage

// File: rtl/pref_dedup_cam.sv
// Combinational duplicate filter: keeps a valid candidate only when its block address
// matches no valid queue entry and no earlier valid candidate of the same cycle.
module pref_dedup_cam
  import pref_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CLA_W = CLA_SIZE
) (
  input  logic [CLA_W-1:0] cand_cla_i    [3],
  input  logic [2:0]       cand_valid_i,
  input  logic [CLA_W-1:0] entry_cla_i   [DEPTH],
  input  logic [DEPTH-1:0] entry_valid_i,
  output logic [2:0]       keep_o
);

  // Match each candidate against the whole entry array and the candidates ahead of it.
  always_comb begin
    keep_o = cand_valid_i;
    for (int k = 0; k < 3; k++) begin
      for (int e = 0; e < DEPTH; e++) begin
        keep_o[k] = keep_o[k] & ~(entry_valid_i[e] & (entry_cla_i[e] == cand_cla_i[k]));
      end
      for (int j = 0; j < k; j++) begin
        keep_o[k] = keep_o[k] & ~(cand_valid_i[j] & (cand_cla_i[j] == cand_cla_i[k]));
      end
    end
  end

endmodule

// File: rtl/pref_issue_queue.sv
// Prefetch issue queue: circular FIFO of block addresses fed by up to 3 candidates per
// cycle, drained one per cycle to L2. Duplicate filtering is built only with PREF_DEDUP_EN.
module pref_issue_queue #(
  parameter int QUEUE_DEPTH     = 16,
  parameter int ADDR_SIZE       = pref_pkg::ADDR_SIZE,
  parameter int LOG2_BLOCK_SIZE = pref_pkg::LOG2_BLOCK_SIZE,
  parameter int CNT_W           = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_SIZE-1:0]           pref_addr1_i,
  input  logic                           pref_valid1_i,
  input  logic [ADDR_SIZE-1:0]           pref_addr2_i,
  input  logic                           pref_valid2_i,
  input  logic [ADDR_SIZE-1:0]           pref_addr3_i,
  input  logic                           pref_valid3_i,
  input  logic                           flush_i,
  output logic [ADDR_SIZE-1:0]           issue_addr_o,
  output logic                           issue_valid_o,
  input  logic                           issue_ready_i,
  output logic [$clog2(QUEUE_DEPTH):0]   occupancy_o,
  output logic [CNT_W-1:0]               drop_count_o
);

  localparam int PW    = $clog2(QUEUE_DEPTH);
  localparam int CW    = PW + 1;
  localparam int SW    = CNT_W + 2;
  localparam int CLA_W = ADDR_SIZE - LOG2_BLOCK_SIZE;

  logic [CLA_W-1:0]       mem_q [QUEUE_DEPTH];
  logic [CLA_W-1:0]       mem_d [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CNT_W-1:0]       drop_q, drop_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [ADDR_SIZE-1:0]   issue_addr_q, issue_addr_d;

  logic [CLA_W-1:0]       cand_cla_s [3];
  logic [2:0]             cand_valid_s;
  logic [2:0]             keep_s;
  logic                   pop_s;
  logic                   fits_s;
  logic [CW-1:0]          free_s;
  logic [1:0]             enq_s;
  logic [1:0]             drops_s;
  logic [PW-1:0]          wr_idx_s;
  logic [SW-1:0]          drop_sum_s;
  logic [3*LOG2_BLOCK_SIZE-1:0] unused_offset_s;

  assign cand_cla_s[0]   = pref_addr1_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  assign cand_cla_s[1]   = pref_addr2_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  assign cand_cla_s[2]   = pref_addr3_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  assign cand_valid_s    = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
  assign unused_offset_s = {pref_addr3_i[LOG2_BLOCK_SIZE-1:0], pref_addr2_i[LOG2_BLOCK_SIZE-1:0],
                            pref_addr1_i[LOG2_BLOCK_SIZE-1:0]};

`ifdef PREF_DEDUP_EN
  pref_dedup_cam #(
    .DEPTH (QUEUE_DEPTH),
    .CLA_W (CLA_W)
  ) u_dedup_cam (
    .cand_cla_i    (cand_cla_s),
    .cand_valid_i  (cand_valid_s),
    .entry_cla_i   (mem_q),
    .entry_valid_i (valid_q),
    .keep_o        (keep_s)
  );
`else
  assign keep_s = cand_valid_s;
`endif

  // Next-state: pop, in-order enqueue into free slots, saturating drop count, flush.
  always_comb begin
    mem_d      = mem_q;
    valid_d    = valid_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_d     = drop_q;
    enq_s      = 2'd0;
    drops_s    = 2'd0;
    fits_s     = 1'b0;
    wr_idx_s   = '0;
    drop_sum_s = '0;
    pop_s      = issue_valid_q & issue_ready_i;
    // A popped slot is reusable in the same cycle, so a full queue can still accept one.
    free_s     = CW'(QUEUE_DEPTH) - count_q + CW'(pop_s);
    if (flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_s) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end else begin
        head_d = head_q;
      end
      for (int k = 0; k < 3; k++) begin
        wr_idx_s = tail_q + PW'(enq_s);
        fits_s   = CW'(enq_s) < free_s;
        if (keep_s[k] && fits_s) begin
          mem_d[wr_idx_s]   = cand_cla_s[k];
          valid_d[wr_idx_s] = 1'b1;
          enq_s             = enq_s + 2'd1;
        end else begin
          drops_s = drops_s + {1'b0, keep_s[k]};
        end
      end
      tail_d     = tail_q + PW'(enq_s);
      count_d    = count_q + CW'(enq_s) - CW'(pop_s);
      drop_sum_s = SW'(drop_q) + SW'(drops_s);
      drop_d     = (drop_sum_s[SW-1:CNT_W] != '0) ? '1 : drop_sum_s[CNT_W-1:0];
    end
    issue_valid_d = valid_d[head_d];
    issue_addr_d  = issue_valid_d ? {mem_d[head_d], {LOG2_BLOCK_SIZE{1'b0}}} : '0;
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      drop_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_addr_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      drop_q        <= drop_d;
      issue_valid_q <= issue_valid_d;
      issue_addr_q  <= issue_addr_d;
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign issue_addr_o  = issue_addr_q;
  assign issue_valid_o = issue_valid_q;
  assign occupancy_o   = count_q;
  assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_pref_issue_queue.sv
// Scoreboard bench for pref_issue_queue (DEPTH 16, CNT_W 4): a queue-based reference model
// predicts the post-edge outputs; a monitor pops those predictions and compares each cycle.
module tb_pref_issue_queue;

  localparam int DEPTH = 16;
  localparam int CNTW  = 4;
  localparam int DMAX  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pref_addr1_i = '0, pref_addr2_i = '0, pref_addr3_i = '0;
  logic        pref_valid1_i = 1'b0, pref_valid2_i = 1'b0, pref_valid3_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        issue_ready_i = 1'b0;
  logic [63:0] issue_addr_o;
  logic        issue_valid_o;
  logic [4:0]  occupancy_o;
  logic [CNTW-1:0] drop_count_o;

  always #5 clk = ~clk;

  pref_issue_queue #(
    .QUEUE_DEPTH     (DEPTH),
    .ADDR_SIZE       (64),
    .LOG2_BLOCK_SIZE (6),
    .CNT_W           (CNTW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pref_addr1_i  (pref_addr1_i),
    .pref_valid1_i (pref_valid1_i),
    .pref_addr2_i  (pref_addr2_i),
    .pref_valid2_i (pref_valid2_i),
    .pref_addr3_i  (pref_addr3_i),
    .pref_valid3_i (pref_valid3_i),
    .flush_i       (flush_i),
    .issue_addr_o  (issue_addr_o),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .occupancy_o   (occupancy_o),
    .drop_count_o  (drop_count_o)
  );

  typedef struct {
    logic        v;
    logic [63:0] a;
    int          occ;
    int          drops;
  } exp_t;

  exp_t        exp_q[$];
  logic [57:0] mq[$];
  int          m_drops = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic void check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: the queue is a list of block addresses in issue order.
  task automatic model_step(input logic r, input logic f, input logic rd,
                            input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] a3,
                            input logic [2:0] v);
    logic [57:0] c[3];
    logic [2:0]  dup;
    int          free, enq;
    logic        pop;
    exp_t        e;
    c[0] = a1[63:6];
    c[1] = a2[63:6];
    c[2] = a3[63:6];
    if (r) begin
      mq.delete();
      m_drops = 0;
    end else if (f) begin
      mq.delete();
    end else begin
      dup = 3'b000;
`ifdef PREF_DEDUP_EN
      for (int k = 0; k < 3; k++) begin
        foreach (mq[i]) if (mq[i] == c[k]) dup[k] = 1'b1;
        for (int j = 0; j < k; j++) if (v[j] && c[j] == c[k]) dup[k] = 1'b1;
      end
`endif
      pop  = (mq.size() > 0) && rd;
      free = DEPTH - mq.size() + (pop ? 1 : 0);
      if (pop) void'(mq.pop_front());
      enq = 0;
      for (int k = 0; k < 3; k++) begin
        if (v[k] && !dup[k]) begin
          if (enq < free) begin
            mq.push_back(c[k]);
            enq++;
          end else if (m_drops < DMAX) begin
            m_drops++;
          end
        end
      end
    end
    e.v     = (mq.size() > 0);
    e.a     = e.v ? {mq[0], 6'b000000} : 64'd0;
    e.occ   = mq.size();
    e.drops = m_drops;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic f, input logic rd,
                     input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] a3,
                     input logic [2:0] v);
    @(negedge clk);
    rst = r;
    flush_i = f;
    issue_ready_i = rd;
    pref_addr1_i = a1;
    pref_addr2_i = a2;
    pref_addr3_i = a3;
    pref_valid1_i = v[0];
    pref_valid2_i = v[1];
    pref_valid3_i = v[2];
    model_step(r, f, rd, a1, a2, a3, v);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one prediction per clock edge, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check64("issue_valid", {63'd0, issue_valid_o}, {63'd0, e.v});
        if (e.v) check64("issue_addr", issue_addr_o, e.a);
        check64("occupancy", {59'd0, occupancy_o}, 64'(e.occ));
        check64("drop_count", {60'd0, drop_count_o}, 64'(e.drops));
      end
    end
  end

  initial begin
    logic [63:0] a1, a2, a3;
    logic        r, f, rd;
    int          n;

    // Reset, then a single candidate with one-cycle latency.
    cyc(1'b1, 1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 3'b000);
    cyc(1'b1, 1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 3'b000);
    after_edge();
    check64("reset_valid", {63'd0, issue_valid_o}, 64'd0);
    check64("reset_drops", {60'd0, drop_count_o}, 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 64'h1000_0047, 64'd0, 64'd0, 3'b001);
    after_edge();
    check64("single_addr", issue_addr_o, 64'h1000_0040);
    cyc(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 3'b000);
    after_edge();
    check64("single_drained", {59'd0, occupancy_o}, 64'd0);

    // Three candidates against a stalled cache, then release.
    cyc(1'b0, 1'b0, 1'b0, 64'h2000, 64'h2040, 64'h2080, 3'b111);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 3'b000);
    after_edge();
    check64("stall_occ", {59'd0, occupancy_o}, 64'd3);
    check64("stall_addr", issue_addr_o, 64'h2000);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 3'b000);

    // Overflow: 18 distinct blocks into 16 slots, then one slot freed by a pop.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 64'h10_0000 + 64'(n) * 64, 64'h10_0000 + 64'(n + 1) * 64,
          64'h10_0000 + 64'(n + 2) * 64, 3'b111);
      n += 3;
    end
    after_edge();
    check64("ovf_occ", {59'd0, occupancy_o}, 64'd16);
    check64("ovf_drops", {60'd0, drop_count_o}, 64'd2);
    cyc(1'b0, 1'b0, 1'b1, 64'h10_0000 + 64'(n) * 64, 64'h10_0000 + 64'(n + 1) * 64,
        64'h10_0000 + 64'(n + 2) * 64, 3'b111);
    after_edge();
    check64("ovf_pop_drops", {60'd0, drop_count_o}, 64'd4);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 3'b000);

    // Duplicates against the queue and within the same cycle.
    cyc(1'b0, 1'b0, 1'b0, 64'h3000, 64'd0, 64'd0, 3'b001);
    cyc(1'b0, 1'b0, 1'b0, 64'h3010, 64'h3040, 64'h3040, 3'b111);
    after_edge();
`ifdef PREF_DEDUP_EN
    check64("dedup_occ", {59'd0, occupancy_o}, 64'd2);
`else
    check64("nodedup_occ", {59'd0, occupancy_o}, 64'd4);
`endif
    check64("dedup_drops", {60'd0, drop_count_o}, 64'd4);

    // Flush with a same-cycle pop and candidates.
    cyc(1'b0, 1'b0, 1'b0, 64'h4000, 64'h4040, 64'h4080, 3'b111);
    cyc(1'b0, 1'b1, 1'b1, 64'h5000, 64'h5040, 64'd0, 3'b011);
    after_edge();
    check64("flush_occ", {59'd0, occupancy_o}, 64'd0);
    check64("flush_valid", {63'd0, issue_valid_o}, 64'd0);
    check64("flush_drops", {60'd0, drop_count_o}, 64'd4);

    // Alternate fill and drain so both pointers wrap twice.
    n = 0;
    for (int i = 0; i < 44; i++) begin
      if (i % 4 == 0) begin
        cyc(1'b0, 1'b0, 1'b0, 64'h6_0000 + 64'(n) * 64, 64'h6_0000 + 64'(n + 1) * 64,
            64'h6_0000 + 64'(n + 2) * 64, 3'b111);
        n += 3;
      end else begin
        cyc(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 3'b000);
      end
    end

    // Saturation: 20 more drops must stop the 4-bit counter at 15.
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 64'h8_0000 + 64'(n) * 64, 64'h8_0000 + 64'(n + 1) * 64,
          64'h8_0000 + 64'(n + 2) * 64, 3'b111);
      n += 3;
    end
    after_edge();
    check64("sat_drops", {60'd0, drop_count_o}, 64'd15);

    // Reset overrides flush and candidates.
    cyc(1'b1, 1'b1, 1'b1, 64'h9000, 64'h9040, 64'h9080, 3'b111);
    after_edge();
    check64("rst_occ", {59'd0, occupancy_o}, 64'd0);
    check64("rst_drops", {60'd0, drop_count_o}, 64'd0);

    // Random traffic from a small block pool to provoke duplicates, stalls and overflow.
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 31) == 0);
      rd = ((i % 100) < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      a1 = 64'h7000_0000 + 64'($urandom_range(0, 23)) * 64 + 64'($urandom_range(0, 63));
      a2 = 64'h7000_0000 + 64'($urandom_range(0, 23)) * 64 + 64'($urandom_range(0, 63));
      a3 = 64'h7000_0000 + 64'($urandom_range(0, 23)) * 64 + 64'($urandom_range(0, 63));
      cyc(r, f, rd, a1, a2, a3, 3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 3'b000);
    after_edge();
    after_edge();
    check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
